// File: rtl/alu_pkg.sv
// Shared opcodes, widths and slice-level types for the 64-bit execute-stage ALU.
package alu_pkg;

    localparam int unsigned WIDTH = 64;

    localparam logic [2:0] ALU_PASS_B   = 3'b000;
    localparam logic [2:0] ALU_ADD      = 3'b010;
    localparam logic [2:0] ALU_SUBTRACT = 3'b011;
    localparam logic [2:0] ALU_AND      = 3'b100;
    localparam logic [2:0] ALU_OR       = 3'b101;
    localparam logic [2:0] ALU_XOR      = 3'b110;
    localparam logic [2:0] ALU_SLT      = 3'b111;

    typedef enum logic [2:0] {
        SL_PASS_B = 3'd0,
        SL_AND    = 3'd1,
        SL_OR     = 3'd2,
        SL_XOR    = 3'd3,
        SL_SUM    = 3'd4
    } slice_op_e;

    typedef struct packed {
        logic negative;
        logic zero;
        logic overflow;
        logic carry_out;
    } alu_flags_t;

endpackage

// File: rtl/alu_bitslice.sv
// One-bit ALU slice: logic ops plus a full adder with optional B inversion.
module alu_bitslice
    import alu_pkg::*;
(
    input  logic      i_a,
    input  logic      i_b,
    input  logic      i_cin,
    input  logic      i_binv,
    input  slice_op_e i_op,
    output logic      o_res_c,
    output logic      o_cout_c
);

    logic w_b;

    assign w_b      = i_b ^ i_binv;
    assign o_cout_c = (i_a & w_b) | (i_cin & (i_a ^ w_b));

    always_comb begin
        o_res_c = 1'b0;
        case (i_op)
            SL_PASS_B: o_res_c = i_b;
            SL_AND:    o_res_c = i_a & i_b;
            SL_OR:     o_res_c = i_a | i_b;
            SL_XOR:    o_res_c = i_a ^ i_b;
            SL_SUM:    o_res_c = i_a ^ w_b ^ i_cin;
            default:   o_res_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_64.sv
// 64-bit registered ALU built from a ripple chain of alu_bitslice instances.
// Define ALU_SLT_EN to make opcode 111 a signed set-less-than.
module alu_64
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       cntrl,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out
);

    slice_op_e        w_slice_op;
    logic             w_binv;
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_slice_res;
    logic             w_add_ovf;
    logic [WIDTH-1:0] w_next_res;
    logic             w_next_ovf;
    logic             w_next_cout;
    logic [WIDTH-1:0] r_result;
    alu_flags_t       r_flags;

    // Subtract (and SLT) reuse the adder as A + ~B + 1.
    always_comb begin
        w_slice_op = SL_PASS_B;
        w_binv     = 1'b0;
        case (cntrl)
            ALU_PASS_B:   w_slice_op = SL_PASS_B;
            ALU_ADD:      w_slice_op = SL_SUM;
            ALU_SUBTRACT: begin
                w_slice_op = SL_SUM;
                w_binv     = 1'b1;
            end
            ALU_AND:      w_slice_op = SL_AND;
            ALU_OR:       w_slice_op = SL_OR;
            ALU_XOR:      w_slice_op = SL_XOR;
`ifdef ALU_SLT_EN
            ALU_SLT: begin
                w_slice_op = SL_SUM;
                w_binv     = 1'b1;
            end
`endif
            default:      w_slice_op = SL_PASS_B;
        endcase
    end

    assign w_carry[0] = w_binv;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        alu_bitslice u_slice (
            .i_a      (A[gi]),
            .i_b      (B[gi]),
            .i_cin    (w_carry[gi]),
            .i_binv   (w_binv),
            .i_op     (w_slice_op),
            .o_res_c  (w_slice_res[gi]),
            .o_cout_c (w_carry[gi+1])
        );
    end

    assign w_add_ovf = w_carry[WIDTH-1] ^ w_carry[WIDTH];

    // Select the value and arithmetic flags to be captured this edge.
    always_comb begin
        w_next_res  = '0;
        w_next_ovf  = 1'b0;
        w_next_cout = 1'b0;
        case (cntrl)
            ALU_PASS_B, ALU_AND, ALU_OR, ALU_XOR: w_next_res = w_slice_res;
            ALU_ADD, ALU_SUBTRACT: begin
                w_next_res  = w_slice_res;
                w_next_ovf  = w_add_ovf;
                w_next_cout = w_carry[WIDTH];
            end
`ifdef ALU_SLT_EN
            ALU_SLT: w_next_res = WIDTH'(w_slice_res[WIDTH-1] ^ w_add_ovf);
`endif
            default: w_next_res = '0;
        endcase
    end

    // Reset value keeps zero consistent with a cleared result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result          <= '0;
            r_flags.negative  <= 1'b0;
            r_flags.zero      <= 1'b1;
            r_flags.overflow  <= 1'b0;
            r_flags.carry_out <= 1'b0;
        end else begin
            r_result          <= w_next_res;
            r_flags.negative  <= w_next_res[WIDTH-1];
            r_flags.zero      <= (w_next_res == '0);
            r_flags.overflow  <= w_next_ovf;
            r_flags.carry_out <= w_next_cout;
        end
    end

    assign result    = r_result;
    assign negative  = r_flags.negative;
    assign zero      = r_flags.zero;
    assign overflow  = r_flags.overflow;
    assign carry_out = r_flags.carry_out;

endmodule

// File: tb/tb_alu_64.sv
// Randomized self-checking bench for alu_64 against an arithmetic reference model.
// Honors ALU_SLT_EN in the model when the macro is defined.
module tb_alu_64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic [63:0] result;
    logic        negative;
    logic        zero;
    logic        overflow;
    logic        carry_out;

    int n_cmp = 0;
    int n_mis = 0;

`ifdef ALU_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    // {negative, zero, overflow, carry_out, result}
    localparam logic [67:0] RST_VAL = {4'b0100, 64'd0};

    logic [67:0] prev_exp;

    alu_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (a),
        .B         (b),
        .cntrl     (op),
        .result    (result),
        .negative  (negative),
        .zero      (zero),
        .overflow  (overflow),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got nzvc=%b res=0x%016h, expected nzvc=%b res=0x%016h",
                     tag, obs[67:64], obs[63:0], exp[67:64], exp[63:0]);
        end
    endtask

    function automatic logic [67:0] dut_out();
        return {negative, zero, overflow, carry_out, result};
    endfunction

    // Reference: plain 65-bit arithmetic, sign-rule overflow, signed compare for SLT.
    function automatic logic [67:0] ref_alu(input logic [63:0] x, input logic [63:0] y,
                                             input logic [2:0] o);
        logic [64:0] s;
        logic [63:0] r;
        logic        v;
        logic        c;
        r = 64'd0;
        v = 1'b0;
        c = 1'b0;
        case (o)
            3'b000: r = y;
            3'b010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[63:0];
                c = s[64];
                v = (x[63] == y[63]) && (r[63] != x[63]);
            end
            3'b011: begin
                s = {1'b0, x} + {1'b0, ~y} + 65'd1;
                r = s[63:0];
                c = s[64];
                v = (x[63] != y[63]) && (r[63] != x[63]);
            end
            3'b100: r = x & y;
            3'b101: r = x | y;
            3'b110: r = x ^ y;
            3'b111: if (SLT_EN) r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            default: r = 64'd0;
        endcase
        return {r[63], (r == 64'd0), v, c, r};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Apply between edges, confirm outputs still hold the previous op, then check one edge later.
    task automatic run_op(input string tag, input logic [63:0] x, input logic [63:0] y,
                          input logic [2:0] o);
        logic [67:0] e;
        @(negedge clk);
        a  = x;
        b  = y;
        op = o;
        #1;
        check_eq({tag, "_hold"}, dut_out(), prev_exp);
        e = ref_alu(x, y, o);
        @(posedge clk);
        #1;
        check_eq(tag, dut_out(), e);
        prev_exp = e;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        a        = 64'd5;
        b        = 64'd3;
        op       = 3'b010;
        prev_exp = RST_VAL;
        #22;
        check_eq("reset_init", dut_out(), RST_VAL);
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_op("rst_first_add", 64'd5, 64'd3, 3'b010);
        check_eq("rst_first_const", dut_out(), {4'b0000, 64'd8});

        // Asynchronous reset in the middle of a cycle, no clock edge needed.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("rst_async", dut_out(), RST_VAL);
        @(posedge clk);
        #1;
        check_eq("rst_held", dut_out(), RST_VAL);
        prev_exp = RST_VAL;
        #1 rst_n = 1'b1;
        run_op("rst_release_add", 64'd5, 64'd3, 3'b010);
        check_eq("rst_release_const", dut_out(), {4'b0000, 64'd8});

        // Directed add/sub corners.
        run_op("add_1_1", 64'd1, 64'd1, 3'b010);
        check_eq("add_1_1_const", dut_out(), {4'b0000, 64'd2});
        run_op("add_12_256", 64'd12, 64'd256, 3'b010);
        check_eq("add_12_256_const", dut_out(), {4'b0000, 64'd268});
        run_op("add_0_0", 64'd0, 64'd0, 3'b010);
        check_eq("add_0_0_const", dut_out(), {4'b0100, 64'd0});
        run_op("add_maxpos_1", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        check_eq("add_maxpos_const", dut_out(), {4'b1010, 64'h8000_0000_0000_0000});
        run_op("add_allones_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010);
        check_eq("add_allones_const", dut_out(), {4'b0101, 64'd0});
        run_op("sub_10_8", 64'd10, 64'd8, 3'b011);
        check_eq("sub_10_8_const", dut_out(), {4'b0001, 64'd2});
        run_op("sub_100_57", 64'd100, 64'd57, 3'b011);
        check_eq("sub_100_57_const", dut_out(), {4'b0001, 64'd43});
        run_op("sub_8_10", 64'd8, 64'd10, 3'b011);
        check_eq("sub_8_10_const", dut_out(), {4'b1000, 64'hFFFF_FFFF_FFFF_FFFE});
        run_op("sub_minneg_1", 64'h8000_0000_0000_0000, 64'd1, 3'b011);
        check_eq("sub_minneg_const", dut_out(), {4'b0011, 64'h7FFF_FFFF_FFFF_FFFF});
        run_op("xor_same", 64'hF0F0, 64'hF0F0, 3'b110);
        check_eq("xor_same_const", dut_out(), {4'b0100, 64'd0});

        for (int i = 0; i < 100; i++) run_op("pass_b_rand", rnd64(), rnd64(), 3'b000);
        run_op("pass_b_zero", rnd64(), 64'd0, 3'b000);
        for (int i = 0; i < 50; i++) run_op("and_rand", rnd64(), rnd64(), 3'b100);
        for (int i = 0; i < 50; i++) run_op("or_rand", rnd64(), rnd64(), 3'b101);
        for (int i = 0; i < 50; i++) run_op("xor_rand", rnd64(), rnd64(), 3'b110);

        // Opcode changes every cycle, including the unused 001 slot.
        for (int i = 0; i < 10; i++) begin
            run_op("b2b_add", rnd64(), rnd64(), 3'b010);
            run_op("b2b_sub", rnd64(), rnd64(), 3'b011);
            run_op("b2b_and", rnd64(), rnd64(), 3'b100);
            run_op("b2b_op001", rnd64(), rnd64(), 3'b001);
            check_eq("op001_const", dut_out(), {4'b0100, 64'd0});
        end

        run_op("slt_m1_1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b111);
        check_eq("slt_m1_1_const", dut_out(),
                 SLT_EN ? {4'b0000, 64'd1} : {4'b0100, 64'd0});
        run_op("slt_1_m1", 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 3'b111);
        run_op("slt_minneg_1", 64'h8000_0000_0000_0000, 64'd1, 3'b111);
        for (int i = 0; i < 20; i++) run_op("op111_rand", rnd64(), rnd64(), 3'b111);

        for (int i = 0; i < 200; i++) begin
            logic [2:0] ro;
            ro = 3'($urandom_range(0, 7));
            run_op("mixed_rand", rnd64(), rnd64(), ro);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
